// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: the active-low segment
// code table, the blank pattern and the scan-decoder FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low codes for 0..F, bit 6 = segment a, bit 0 = segment g.
    localparam logic [6:0] SEG_CODE [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_COLLECT,
        ST_OFFER
    } scan_state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup of an active-low segment pattern to a hex nibble;
// anything outside the code table decodes to 0 with err_o set.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nib_o,
    output logic       err_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path can infer a latch.
        nib_o = 4'h0;
        err_o = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_CODE[i]) begin
                nib_o = 4'(i);
                err_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed active-low 7-segment bus, debounces each strobed digit,
// decodes it and assembles whole frames offered over a valid/ready handshake.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [DIGITS-1:0]   an_i,
    input  logic [6:0]          seg_i,
    output logic [4*DIGITS-1:0] frame_o,
    output logic [DIGITS-1:0]   err_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                ovf_o
);

    localparam int              IW       = $clog2(DIGITS);
    localparam logic [7:0]      CNT_MAX  = 8'(STABLE_CYC);
    localparam logic [IW-1:0]   LAST_IDX = IW'(DIGITS - 1);

    logic [DIGITS-1:0]   an_s1_q, an_s2_q, an_prev_q;
    logic [6:0]          seg_s1_q, seg_s2_q, seg_prev_q;
    logic [7:0]          cnt_q, cnt_d;
    scan_state_e         state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] part_nib_q, part_nib_d;
    logic [DIGITS-1:0]   part_err_q, part_err_d;
    logic [4*DIGITS-1:0] frame_q, frame_d;
    logic [DIGITS-1:0]   err_q, err_d;
    logic                ovf_q, ovf_d;

    logic          same;
    logic          cap;
    logic [IW-1:0] cap_idx;
    logic [3:0]    dec_nib;
    logic          dec_err;

    seg7_to_hex u_dec (
        .seg_i (seg_s2_q),
        .nib_o (dec_nib),
        .err_o (dec_err)
    );

    assign same = ({an_s2_q, seg_s2_q} == {an_prev_q, seg_prev_q});

    always_comb begin
        cnt_d = 8'd0;
        if (same) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
        end
    end

    // Fires only on the step into saturation and only for a single lit anode.
    assign cap = same && (cnt_q == CNT_MAX - 8'd1) && $onehot(~an_s2_q);

    always_comb begin
        cap_idx = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (!an_s2_q[k]) cap_idx = IW'(k);
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        part_nib_d = part_nib_q;
        part_err_d = part_err_q;
        frame_d    = frame_q;
        err_d      = err_q;
        ovf_d      = 1'b0;
        unique case (state_q)
            ST_HUNT: begin
                if (cap && cap_idx == '0) begin
                    part_nib_d[3:0] = dec_nib;
                    part_err_d[0]   = dec_err;
                    idx_d           = IW'(1);
                    state_d         = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (cap) begin
                    if (cap_idx == idx_q) begin
                        part_nib_d[4*int'(cap_idx) +: 4] = dec_nib;
                        part_err_d[cap_idx]              = dec_err;
                        if (idx_q == LAST_IDX) begin
                            frame_d = part_nib_d;
                            err_d   = part_err_d;
                            state_d = ST_OFFER;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else if (cap_idx == '0) begin
                        part_nib_d[3:0] = dec_nib;
                        part_err_d[0]   = dec_err;
                        idx_d           = IW'(1);
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
            end
            ST_OFFER: begin
                ovf_d = cap;
                if (ready_i) state_d = ST_HUNT;
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // Reset to the blank pattern so the synchroniser reads as "nothing lit".
            an_s1_q    <= '1;
            an_s2_q    <= '1;
            an_prev_q  <= '1;
            seg_s1_q   <= SEG_BLANK;
            seg_s2_q   <= SEG_BLANK;
            seg_prev_q <= SEG_BLANK;
            cnt_q      <= 8'd0;
            state_q    <= ST_HUNT;
            idx_q      <= '0;
            part_nib_q <= '0;
            part_err_q <= '0;
            frame_q    <= '0;
            err_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the chain.
            an_s1_q    <= an_i;
            an_s2_q    <= an_s1_q;
            an_prev_q  <= an_s2_q;
            seg_s1_q   <= seg_i;
            seg_s2_q   <= seg_s1_q;
            seg_prev_q <= seg_s2_q;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            part_nib_q <= part_nib_d;
            part_err_q <= part_err_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign frame_o = frame_q;
    assign err_o   = err_q;
    assign valid_o = (state_q == ST_OFFER);
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: a run-length / digit-list model
// checked every cycle, directed scenarios pinned with literal frames, then random scans.
module tb_seg7_scan_decoder;

    localparam int DIGITS     = 4;
    localparam int STABLE_CYC = 8;
    localparam int PW         = DIGITS + 7;

    typedef logic [PW-1:0] pair_t;
    localparam pair_t PAIR_IDLE = '1;

    logic                clk;
    logic                rst;
    logic [DIGITS-1:0]   an_i;
    logic [6:0]          seg_i;
    logic                ready_i;
    logic [4*DIGITS-1:0] frame_o;
    logic [DIGITS-1:0]   err_o;
    logic                valid_o;
    logic                ovf_o;

    seg7_scan_decoder #(
        .DIGITS     (DIGITS),
        .STABLE_CYC (STABLE_CYC)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .an_i    (an_i),
        .seg_i   (seg_i),
        .frame_o (frame_o),
        .err_o   (err_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .ovf_o   (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] hex_seg [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // {err, nibble}
    function automatic logic [4:0] decode(input logic [6:0] s);
        for (int i = 0; i < 16; i++) begin
            if (hex_seg[i] == s) return {1'b0, 4'(i)};
        end
        return 5'h10;
    endfunction

    // Model: pins reach the checker two cycles late; a digit is captured when the
    // synchronised pair has been seen for exactly STABLE_CYC+1 consecutive cycles.
    pair_t               sync_q [$];
    pair_t               last_y;
    int                  run;
    int                  col_nib [$];
    bit                  col_err [$];
    bit                  m_pending;
    logic [4*DIGITS-1:0] m_frame;
    logic [DIGITS-1:0]   m_err;
    bit                  m_ovf;

    task automatic model_step();
        pair_t      y;
        bit         cap;
        int         d;
        logic [4:0] dv;
        if (rst) begin
            sync_q = '{PAIR_IDLE, PAIR_IDLE};
            last_y = PAIR_IDLE;
            run    = 1;
            col_nib.delete();
            col_err.delete();
            m_pending = 0;
            m_frame   = '0;
            m_err     = '0;
            m_ovf     = 0;
            return;
        end
        y = sync_q[0];
        if (y == last_y) run++;
        else begin
            run    = 1;
            last_y = y;
        end
        cap = (run == STABLE_CYC + 1) && ($countones(~y[PW-1:7]) == 1);
        d = 0;
        for (int k = 0; k < DIGITS; k++) if (!y[7+k]) d = k;
        dv = decode(y[6:0]);
        void'(sync_q.pop_front());
        sync_q.push_back({an_i, seg_i});

        m_ovf = 0;
        if (m_pending) begin
            m_ovf = cap;
            if (ready_i) m_pending = 0;
        end else if (cap) begin
            if (d == 0) begin
                col_nib.delete();
                col_err.delete();
            end
            if (d == col_nib.size()) begin
                col_nib.push_back(int'(dv[3:0]));
                col_err.push_back(dv[4]);
                if (col_nib.size() == DIGITS) begin
                    for (int k = 0; k < DIGITS; k++) begin
                        m_frame[4*k +: 4] = 4'(col_nib[k]);
                        m_err[k]          = col_err[k];
                    end
                    m_pending = 1;
                    col_nib.delete();
                    col_err.delete();
                end
            end else begin
                col_nib.delete();
                col_err.delete();
            end
        end
    endtask

    always @(posedge clk or posedge rst) model_step();

    int                  frames      = 0;
    int                  valid_cyc   = 0;
    int                  ovf_pulses  = 0;
    logic [4*DIGITS-1:0] last_frame  = '0;
    logic [DIGITS-1:0]   last_err    = '0;

    task automatic compare_and_monitor();
        check("valid_o", valid_o, m_pending);
        check("frame_o", frame_o, m_frame);
        check("err_o",   err_o,   m_err);
        check("ovf_o",   ovf_o,   m_ovf);
        if (valid_o === 1'b1) valid_cyc++;
        if (ovf_o === 1'b1) ovf_pulses++;
        if (valid_o === 1'b1 && ready_i === 1'b1) begin
            frames++;
            last_frame = frame_o;
            last_err   = err_o;
        end
    endtask

    always @(negedge clk) compare_and_monitor();

    task automatic hold(input logic [DIGITS-1:0] an, input logic [6:0] sg, input int n);
        an_i  = an;
        seg_i = sg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input int d, input logic [6:0] sg, input int n);
        logic [DIGITS-1:0] one;
        one = 1;
        hold(~(one << d), sg, n);
    endtask

    task automatic scan(input logic [4*DIGITS-1:0] val);
        for (int d = 0; d < DIGITS; d++) show(d, hex_seg[val[4*d +: 4]], 20);
    endtask

    task automatic check_frame(input string name, input int f_before,
                               input logic [4*DIGITS-1:0] exp_f, input logic [DIGITS-1:0] exp_e);
        check({name, " count"}, 64'(frames - f_before), 64'd1);
        check({name, " frame"}, last_frame, exp_f);
        check({name, " err"},   last_err,   exp_e);
        check({name, " model"}, m_frame,    exp_f);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int f0, v0, o0;

    initial begin
        rst     = 1'b0;
        an_i    = '1;
        seg_i   = 7'h7F;
        ready_i = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset frame_o", frame_o, '0);
        check("reset err_o",   err_o,   '0);
        check("reset valid_o", valid_o, 1'b0);
        check("reset ovf_o",   ovf_o,   1'b0);
        rst = 1'b0;

        // Clean scan, consumer always ready.
        ready_i = 1'b1;
        f0 = frames; v0 = valid_cyc;
        scan(16'h3210);
        check_frame("scan", f0, 16'h3210, 4'b0000);
        check("scan valid cycles", 64'(valid_cyc - v0), 64'd1);

        // Illegal pattern on digit 2.
        f0 = frames;
        show(0, hex_seg[4], 20);
        show(1, hex_seg[5], 20);
        show(2, 7'h7F, 20);
        show(3, hex_seg[7], 20);
        check_frame("illegal", f0, 16'h7054, 4'b0100);

        // Glitching digit 1 never settles: no frame until it does.
        f0 = frames;
        show(0, hex_seg[0], 20);
        for (int i = 0; i < 8; i++) show(1, (i % 2 == 0) ? hex_seg[1] : hex_seg[2], 5);
        check("glitch no frame", 64'(frames - f0), 64'd0);
        show(1, hex_seg[1], 20);
        show(2, hex_seg[2], 20);
        show(3, hex_seg[3], 20);
        check_frame("glitch recover", f0, 16'h3210, 4'b0000);

        // Back-pressure: frame held through two more scans, each capture overflows.
        ready_i = 1'b0;
        f0 = frames;
        scan(16'hABCD);
        o0 = ovf_pulses;
        scan(16'h5A5A);
        scan(16'h1234);
        check("bp no transfer", 64'(frames - f0), 64'd0);
        check("bp valid held",  valid_o, 1'b1);
        check("bp frame held",  frame_o, 16'hABCD);
        check("bp ovf pulses",  64'(ovf_pulses - o0), 64'd8);
        ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_frame("bp release", f0, 16'hABCD, 4'b0000);
        check("bp valid drop", valid_o, 1'b0);
        f0 = frames;
        scan(16'h8765);
        check_frame("bp next", f0, 16'h8765, 4'b0000);

        // Order break 0,1,3 discards the partial frame.
        f0 = frames;
        show(0, hex_seg[9], 20);
        show(1, hex_seg[9], 20);
        show(3, hex_seg[9], 20);
        check("order no frame", 64'(frames - f0), 64'd0);
        scan(16'h4E2F);
        check_frame("order recover", f0, 16'h4E2F, 4'b0000);

        // Asynchronous reset while waiting for digit 2.
        show(0, hex_seg[6], 20);
        show(1, hex_seg[6], 20);
        show(2, hex_seg[6], 3);
        #3 rst = 1'b1;
        #1;
        check("midreset frame_o", frame_o, '0);
        check("midreset err_o",   err_o,   '0);
        check("midreset valid_o", valid_o, 1'b0);
        check("midreset ovf_o",   ovf_o,   1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        f0 = frames;
        scan(16'hC0DE);
        check_frame("after reset", f0, 16'hC0DE, 4'b0000);

        // Random scans: occasional ghost/blank anodes, illegal codes, short windows, back-pressure.
        for (int r = 0; r < 40; r++) begin
            for (int d = 0; d < DIGITS; d++) begin
                logic [DIGITS-1:0] an;
                logic [DIGITS-1:0] one;
                logic [6:0]        sg;
                one = 1;
                an  = ~(one << d);
                if ($urandom_range(0, 9) == 0) an = DIGITS'($urandom);
                sg = ($urandom_range(0, 4) == 0) ? 7'($urandom) : hex_seg[$urandom_range(0, 15)];
                ready_i = ($urandom_range(0, 3) != 0);
                hold(an, sg, $urandom_range(4, 24));
            end
        end
        ready_i = 1'b1;
        repeat (30) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Reverse path of the display driver: watches a multiplexed, active-low 7-segment display bus (anode strobes plus segment lines) and recovers the hex value on it. Each strobed digit's segment pattern is synchronised, debounced, decoded back to a nibble, and assembled into a frame. The frame is offered to a consumer over a valid/ready handshake. Used for display self-check and loopback test of the display path.

## Interface
- DIGITS, 4: number of multiplexed digits (2..8).
- STABLE_CYC, 8: consecutive cycles the synchronised (anode, segment) pair must stay unchanged before a digit is captured (2..255).
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- an_i  in  DIGITS  anode strobes, active-low; bit k selects digit k.
- seg_i  in  7  segments, active-low; bit 6 = a … bit 0 = g.
- frame_o  out  4*DIGITS  decoded frame; digit k occupies bits [4k+3:4k].
- err_o  out  DIGITS  bit k set = digit k pattern was not a legal hex code.
- valid_o  out  1  frame_o/err_o hold a complete frame.
- ready_i  in  1  consumer accepts the frame.
- ovf_o  out  1  one-cycle pulse: a digit was captured while a frame was pending and was discarded.

## Operation
- Input sync: two flop stages on an_i and seg_i. Reset value is all-ones for both, which reads as blanked/inactive.
- Stability counter: cleared when the synchronised pair differs from its previous-cycle value. Otherwise it increments, saturating at STABLE_CYC.
- Capture event: one cycle, raised when the counter steps to STABLE_CYC, so at most one per stable interval.
  - Raised only if the synchronised anode has exactly one zero bit.
  - Zero or several low bits is blanking or ghosting: no event.
- Decode: active-low legal codes, 0..F = 01,4F,12,06,4C,24,20,0F,00,04,08,60,31,42,30,38 (hex, bit 6 = a).
  - Any other pattern decodes to nibble 0 and sets that digit's err bit.
- FSM states HUNT, COLLECT(k), OFFER.
  - HUNT: a capture of digit 0 stores nibble 0 and moves to COLLECT(1). Captures of other digits are ignored.
  - COLLECT(k), capture of digit k: store it. If k = DIGITS-1, go to OFFER; otherwise go to COLLECT(k+1).
  - COLLECT(k), capture of digit 0: restart; store digit 0 and go to COLLECT(1).
  - COLLECT(k), capture of any other digit: the sequence is broken; discard the partial frame and go to HUNT.
  - OFFER: valid_o = 1. On the edge where valid_o && ready_i, go to HUNT.
  - OFFER, any capture event: discard it and pulse ovf_o.
- frame_o and err_o change only on the COLLECT→OFFER transition. They hold their value in HUNT/COLLECT and while OFFER waits.
- Reset mid-operation: immediate return to HUNT. The partial frame is lost.

## Timing
- Reset values: frame_o = 0, err_o = 0, valid_o = 0, ovf_o = 0; counter = 0; state HUNT.
- Input latency: a change on the pins is seen by the stability logic 2 cycles later. Capture fires STABLE_CYC cycles after that, with no further input change.
- valid_o rises on the cycle after the last digit's capture event.
- Handshake:
  - Transfer on the edge where valid_o && ready_i; valid_o is low from the next cycle.
  - ready_i may be held high permanently.
  - valid_o never drops without a transfer (except at reset).
- Capture on the transfer edge itself: treated as an OFFER capture (ovf_o pulses, data dropped). HUNT begins the next cycle.
- ovf_o is high in the cycle after the discarded capture event, for one cycle.
- Throughput: one frame per full display scan, plus one handshake cycle.

## Structure
- Shared package seg7_pkg:
  - the 16-entry active-low segment code table (the same table the display encoder uses);
  - the FSM state enum;
  - a SEG_BLANK = 7'h7F constant.
- Sub-module seg7_to_hex:
  - combinational lookup, seg[6:0] → {err, nibble[3:0]};
  - instantiated once on the synchronised segment bus.
- The top holds the synchroniser, the stability counter, the FSM and the frame registers.

## Test plan
- Scan: DIGITS=4, STABLE_CYC=8, digits 0..3 driven 01,4F,12,06 for 20 cycles each, ready_i=1 → valid_o one cycle, frame_o=16'h3210, err_o=0.
- Illegal pattern: digit 2 driven 7F → frame_o[11:8]=0, err_o=4'b0100, other nibbles correct.
- Glitch rejection: segment toggles every 5 cycles while digit 1 is strobed (STABLE_CYC=8) → no capture; sequence stalls, no valid_o until a stable window occurs.
- Back-pressure: ready_i=0 for two scans after frame 16'hABCD → valid_o held, frame_o stays 16'hABCD, ovf_o pulses once per captured digit. ready_i=1 → transfer, HUNT, next frame accepted.
- Order break: strobe sequence 0,1,3 → partial frame discarded, no valid_o. The next clean 0..3 scan produces a correct frame.
- Async reset asserted during COLLECT(2) → all outputs 0 immediately; a full scan after release yields a correct frame.
